// File: rtl/ising_local_field.sv
// Ising local-field engine: holds an N x N signed coupling matrix and, on start,
// accumulates h[r] = sum_c term(r,c) over all rows in parallel, one column per cycle.
module ising_local_field #(
    parameter int N         = 4,
    parameter int DATABITS  = 16,
    parameter int ACCBITS   = DATABITS + $clog2(N) + 1,
    parameter int ZERO_DIAG = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_row,
    input  logic [7:0]                  wr_col,
    input  logic signed [DATABITS-1:0]  wr_data,
    input  logic                        start,
    input  logic                        mode,
    input  logic [N-1:0]                spin_in,
    output logic                        busy,
    output logic                        done,
    output logic [ACCBITS*N-1:0]        field_out
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      state_q;
    logic [CW-1:0]               col_q;
    logic                        mode_q;
    logic [N-1:0]                spin_q;
    logic signed [DATABITS-1:0]  j_q   [N][N];
    logic signed [ACCBITS-1:0]   acc_q [N];
    logic signed [ACCBITS-1:0]   acc_d [N];
    logic signed [ACCBITS-1:0]   term_s [N];
    logic                        busy_q;
    logic                        done_q;
    logic [ACCBITS*N-1:0]        field_q;
    logic                        wr_ok_s;

    assign busy      = busy_q;
    assign done      = done_q;
    assign field_out = field_q;

    // Writes land only in IDLE so J cannot shift under a running sum
    assign wr_ok_s = wr_en && (state_q == S_IDLE) &&
                     ({24'd0, wr_row} < 32'(N)) && ({24'd0, wr_col} < 32'(N));

    // Per-row term for the current column, sign-extended before negation so -J(min) is exact
    always_comb begin
        for (int r = 0; r < N; r++) begin
            logic signed [ACCBITS-1:0] jx;
            jx       = {{(ACCBITS-DATABITS){j_q[r][col_q][DATABITS-1]}}, j_q[r][col_q]};
            term_s[r] = '0;
            if ((ZERO_DIAG != 0) && (r == int'(col_q))) begin
                term_s[r] = '0;
            end else if (spin_q[col_q]) begin
                term_s[r] = jx;
            end else if (mode_q) begin
                term_s[r] = -jx;
            end else begin
                term_s[r] = '0;
            end
            acc_d[r] = acc_q[r] + term_s[r];
        end
    end

    // Control FSM, coupling storage, accumulators and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            mode_q  <= 1'b0;
            spin_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            field_q <= '0;
            for (int r = 0; r < N; r++) begin
                acc_q[r] <= '0;
                for (int c = 0; c < N; c++) begin
                    j_q[r][c] <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wr_ok_s) begin
                        j_q[wr_row[CW-1:0]][wr_col[CW-1:0]] <= wr_data;
                    end
                    if (start) begin
                        mode_q  <= mode;
                        spin_q  <= spin_in;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ACC;
                        for (int r = 0; r < N; r++) begin
                            acc_q[r] <= '0;
                        end
                    end
                end
                S_ACC: begin
                    for (int r = 0; r < N; r++) begin
                        acc_q[r] <= acc_d[r];
                    end
                    if (col_q == CW'(N - 1)) begin
                        col_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                S_DONE: begin
                    for (int r = 0; r < N; r++) begin
                        field_q[r*ACCBITS +: ACCBITS] <= acc_q[r];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    col_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ising_local_field.sv
// Scoreboard bench: two instances (ZERO_DIAG=0 and 1) share stimulus; each done pulse
// is matched against a queued expectation of field values and completion cycle.
module tb_ising_local_field;

    localparam int N  = 4;
    localparam int DB = 16;
    localparam int AW = DB + $clog2(N) + 1;
    localparam int FW = AW * N;

    typedef struct {
        logic [FW-1:0] f;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [7:0]    wr_row;
    logic [7:0]    wr_col;
    logic [DB-1:0] wr_data;
    logic          start;
    logic          mode;
    logic [N-1:0]  spin_in;
    logic          busy_a, done_a, busy_b, done_b;
    logic [FW-1:0] field_a, field_b;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t qa[$];
    exp_t qb[$];

    ising_local_field #(.N(N), .DATABITS(DB), .ZERO_DIAG(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start), .mode(mode), .spin_in(spin_in),
        .busy(busy_a), .done(done_a), .field_out(field_a)
    );

    ising_local_field #(.N(N), .DATABITS(DB), .ZERO_DIAG(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start), .mode(mode), .spin_in(spin_in),
        .busy(busy_b), .done(done_b), .field_out(field_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [FW-1:0] pk(input int r0, input int r1, input int r2, input int r3);
        return {AW'(r3), AW'(r2), AW'(r1), AW'(r0)};
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitors: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            if (qa.size() == 0) begin
                chk("unexpected_done_a", FW'(1), FW'(0));
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("field_a", field_a, e.f);
                chk("latency_a", FW'(cyc), FW'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done_b === 1'b1) begin
            if (qb.size() == 0) begin
                chk("unexpected_done_b", FW'(1), FW'(0));
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("field_b", field_b, e.f);
                chk("latency_b", FW'(cyc), FW'(e.cyc));
            end
        end
    end

    task automatic wr(input int r, input int c, input int d);
        wr_en   = 1'b1;
        wr_row  = 8'(r);
        wr_col  = 8'(c);
        wr_data = DB'(d);
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    // Drive start so it is accepted at the next edge; optionally queue the expected result
    task automatic issue(input logic m, input logic [N-1:0] s, input logic push,
                         input logic [FW-1:0] ea, input logic [FW-1:0] eb);
        exp_t e;
        start   = 1'b1;
        mode    = m;
        spin_in = s;
        @(posedge clk); #1;
        start   = 1'b0;
        wr_en   = 1'b0;
        if (push) begin
            e.cyc = cyc + N + 1;
            e.f = ea; qa.push_back(e);
            e.f = eb; qb.push_back(e);
        end
        mode    = ~m;
        spin_in = ~s;
        chk("busy_after_accept", FW'({busy_a, busy_b}), FW'(2'b11));
    endtask

    task automatic finish_run();
        repeat (N) @(posedge clk);
        #1;
        chk("busy_in_done", FW'({busy_a, busy_b}), FW'(2'b11));
        @(posedge clk); #1;
        chk("busy_idle", FW'({busy_a, busy_b}), FW'(2'b00));
    endtask

    task automatic run(input logic m, input logic [N-1:0] s,
                       input logic [FW-1:0] ea, input logic [FW-1:0] eb);
        issue(m, s, 1'b1, ea, eb);
        finish_run();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_row = 8'd0; wr_col = 8'd0; wr_data = 16'd0;
        start = 1'b0; mode = 1'b0; spin_in = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy_done", FW'({busy_a, done_a, busy_b, done_b}), FW'(4'b0000));
        chk("reset_field_a", field_a, FW'(0));
        chk("reset_field_b", field_b, FW'(0));
        rst_n = 1'b1;

        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                wr(r, c, r + c);
            end
        end

        run(1'b0, 4'b0101, pk(2, 4, 6, 8), pk(2, 4, 2, 8));
        run(1'b1, 4'b0101, pk(-2, -2, -2, -2), pk(-2, 0, -6, 4));

        // start held through the DONE cycle is ignored there and accepted in IDLE
        issue(1'b0, 4'b1111, 1'b1, pk(6, 10, 14, 18), pk(6, 8, 10, 12));
        repeat (N) @(posedge clk);
        #1;
        start = 1'b1; mode = 1'b1; spin_in = 4'b0101;
        @(posedge clk); #1;
        issue(1'b1, 4'b0101, 1'b1, pk(-2, -2, -2, -2), pk(-2, 0, -6, 4));
        finish_run();

        // start and write while busy are both ignored
        issue(1'b0, 4'b0101, 1'b1, pk(2, 4, 6, 8), pk(2, 4, 2, 8));
        @(posedge clk); #1;
        start = 1'b1; wr_en = 1'b1; wr_row = 8'd0; wr_col = 8'd0; wr_data = 16'd7;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        repeat (N - 1) @(posedge clk);
        #1;
        run(1'b0, 4'b0001, pk(0, 1, 2, 3), pk(0, 1, 2, 3));

        // reset with the column counter at 2 aborts the run and clears J
        issue(1'b0, 4'b1111, 1'b0, FW'(0), FW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy_done", FW'({busy_a, done_a, busy_b, done_b}), FW'(4'b0000));
        chk("midrst_field_a", field_a, FW'(0));
        chk("midrst_field_b", field_b, FW'(0));
        rst_n = 1'b1;
        run(1'b0, 4'b1111, pk(0, 0, 0, 0), pk(0, 0, 0, 0));

        // most negative coupling negated exactly
        wr(0, 1, -32768);
        run(1'b1, 4'b0000, pk(32768, 0, 0, 0), pk(32768, 0, 0, 0));

        // out-of-range writes ignored; a write with an accepted start is used by that run
        wr(4, 0, 99);
        wr(0, 4, 99);
        wr(6, 0, 99);
        wr_en = 1'b1; wr_row = 8'd1; wr_col = 8'd0; wr_data = 16'd5;
        run(1'b0, 4'b0001, pk(0, 5, 0, 0), pk(0, 5, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("pending_a", FW'(qa.size()), FW'(0));
        chk("pending_b", FW'(qb.size()), FW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
